// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TMO_W  = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    // States that wait on the byte stream; these accept bytes and run the timeout.
    function automatic logic is_wait(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Boot loader: assembles big-endian 16-bit words from a byte stream and writes them
// sequentially into instruction memory while holding the CPU in reset.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 20,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rxValid,
    input  logic [7:0]        rxByte,
    output logic              rxReady,
    output logic [ADDR_W-1:0] instrWriteAddress,
    output logic [15:0]       instrWriteData,
    output logic              instrWriteEnable,
    output logic              cpuReset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rx_ready_q, rx_ready_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                xfer;
    logic [WORD_W-1:0]   rx_word;

    assign xfer    = rxValid & rx_ready_q;
    assign rx_word = {hi_q, rxByte};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        hi_d    = hi_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    hi_d    = rxByte;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    cnt_d   = rx_word;
                    state_d = (rx_word == '0) ? ST_DONE : ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    hi_d    = rxByte;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    data_d  = rx_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - WORD_W'(1);
                state_d = (cnt_q == WORD_W'(1)) ? ST_DONE : ST_DATA_HI;
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte arriving on the expiry cycle still wins over the timeout.
        if (TIMEOUT != 0 && is_wait(state_q) && !xfer) begin
            if (tmo_q == TMO_W'(TIMEOUT)) begin
                state_d = ST_ERROR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (xfer || (state_d != state_q)) begin
            tmo_d = '0;
        end

        rx_ready_d  = is_wait(state_d);
        we_d        = (state_d == ST_WRITE);
        busy_d      = is_wait(state_d) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            hi_q        <= '0;
            tmo_q       <= '0;
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            hi_q        <= hi_d;
            tmo_q       <= tmo_d;
            rx_ready_q  <= rx_ready_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign rxReady           = rx_ready_q;
    assign instrWriteAddress = addr_q;
    assign instrWriteData    = data_q;
    assign instrWriteEnable  = we_q;
    assign cpuReset          = cpu_reset_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: two instances (BASE 0 / TIMEOUT 10, BASE FFFFFh / no timeout).
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_byte;
    logic        sel;

    logic        rdy_a, we_a, cpu_a, busy_a, done_a, err_a;
    logic [19:0] addr_a;
    logic [15:0] data_a;
    logic        rdy_b, we_b, cpu_b, busy_b, done_b, err_b;
    logic [19:0] addr_b;
    logic [15:0] data_b;
    logic        rdy_sel;

    logic [35:0] wq_a[$];
    logic [35:0] wq_b[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(20), .BASE_ADDR(20'h00000), .TIMEOUT(10)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .rxValid(rx_valid), .rxByte(rx_byte),
        .rxReady(rdy_a), .instrWriteAddress(addr_a), .instrWriteData(data_a),
        .instrWriteEnable(we_a), .cpuReset(cpu_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    instr_loader #(.ADDR_W(20), .BASE_ADDR(20'hFFFFF), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .rxValid(rx_valid), .rxByte(rx_byte),
        .rxReady(rdy_b), .instrWriteAddress(addr_b), .instrWriteData(data_b),
        .instrWriteEnable(we_b), .cpuReset(cpu_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    assign rdy_sel = sel ? rdy_b : rdy_a;

    always @(negedge clk) begin
        if (we_a === 1'b1) wq_a.push_back({addr_a, data_a});
        if (we_b === 1'b1) wq_b.push_back({addr_b, data_b});
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr_a(input string tag, input int idx, input logic [19:0] a, input logic [15:0] d);
        logic [35:0] got;
        got = (wq_a.size() > idx) ? wq_a[idx] : 36'hF_FFFF_FFFF;
        check(tag, got, {a, d});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Holds the byte until the selected DUT accepts it, bounded by a cycle budget.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_byte  = b;
        while (rdy_sel !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("rx_ready_wait", {35'd0, rdy_sel}, 36'd1);
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        sel      = 1'b0;
        step();
        step();

        // Reset values: {rdy,we,busy,done,err,cpu}
        check("reset_flags_a", {30'd0, rdy_a, we_a, busy_a, done_a, err_a, cpu_a}, 36'b000001);
        check("reset_addr_a", {16'd0, addr_a}, 36'd0);
        check("reset_data_a", {20'd0, data_a}, 36'd0);
        check("reset_flags_b", {30'd0, rdy_b, we_b, busy_b, done_b, err_b, cpu_b}, 36'b000001);
        check("reset_addr_b", {16'd0, addr_b}, 36'd0);
        reset = 1'b0;

        // Address wrap from FFFFFh
        sel = 1'b1;
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        step(); step();
        check("wrap_done", {35'd0, done_b}, 36'd1);
        check("wrap_count", 36'(wq_b.size()), 36'd2);
        check("wrap_wr0", (wq_b.size() > 0) ? wq_b[0] : 36'hF_FFFF_FFFF, {20'hFFFFF, 16'h1111});
        check("wrap_wr1", (wq_b.size() > 1) ? wq_b[1] : 36'hF_FFFF_FFFF, {20'h00000, 16'h2222});

        reset = 1'b1;
        step();
        reset = 1'b0;
        wq_a.delete();
        wq_b.delete();
        sel = 1'b0;

        // Basic two-word image
        pulse_start();
        check("start_flags", {33'd0, busy_a, rdy_a, cpu_a}, 36'b111);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        step(); step();
        check("t1_flags", {32'd0, done_a, cpu_a, busy_a, rdy_a}, 36'b1000);
        check("t1_count", 36'(wq_a.size()), 36'd2);
        check_wr_a("t1_wr0", 0, 20'h00000, 16'h1234);
        check_wr_a("t1_wr1", 1, 20'h00001, 16'hABCD);

        // Zero-length image
        wq_a.delete();
        pulse_start();
        check("t2_restart", {34'd0, done_a, cpu_a}, 36'b01);
        send_byte(8'h00); send_byte(8'h00);
        check("t2_flags", {34'd0, done_a, rdy_a}, 36'b10);
        check("t2_count", 36'(wq_a.size()), 36'd0);

        // Timeout mid-word, then recovery
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        repeat (10) step();
        check("t4_before", {34'd0, err_a, busy_a}, 36'b01);
        step();
        check("t4_error", {32'd0, err_a, busy_a, cpu_a, rdy_a}, 36'b1010);
        check("t4_nowrite", 36'(wq_a.size()), 36'd0);
        pulse_start();
        check("t4_clear", {35'd0, err_a}, 36'd0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h56); send_byte(8'h78);
        step(); step();
        check("t4_done", {34'd0, done_a, err_a}, 36'b10);
        check("t4_count", 36'(wq_a.size()), 36'd1);
        check_wr_a("t4_wr0", 0, 20'h00000, 16'h5678);

        // Gappy valid stream
        wq_a.delete();
        pulse_start();
        begin
            logic [7:0] stream [10];
            stream = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
            for (int i = 0; i < 10; i++) begin
                int g;
                g = 0;
                while (g < 3 && $urandom_range(0, 1) == 0) begin
                    step();
                    g++;
                end
                send_byte(stream[i]);
            end
        end
        step(); step();
        check("t5_done", {35'd0, done_a}, 36'd1);
        check("t5_count", 36'(wq_a.size()), 36'd4);
        check_wr_a("t5_wr0", 0, 20'h00000, 16'hDEAD);
        check_wr_a("t5_wr1", 1, 20'h00001, 16'hBEEF);
        check_wr_a("t5_wr2", 2, 20'h00002, 16'h0123);
        check_wr_a("t5_wr3", 3, 20'h00003, 16'h4567);

        // Reset mid-load
        wq_a.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hA1); send_byte(8'hB2);
        send_byte(8'hC3);
        reset = 1'b1;
        step();
        check("t6_rst_flags", {30'd0, rdy_a, we_a, busy_a, done_a, err_a, cpu_a}, 36'b000001);
        check("t6_rst_addr", {16'd0, addr_a}, 36'd0);
        check("t6_rst_data", {20'd0, data_a}, 36'd0);
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_byte  = 8'hD4;
        repeat (5) step();
        rx_valid = 1'b0;
        check("t6_count", 36'(wq_a.size()), 36'd1);
        check_wr_a("t6_wr0", 0, 20'h00000, 16'hA1B2);
        check("t6_idle", {34'd0, busy_a, rdy_a}, 36'b00);

        // start while busy is ignored
        wq_a.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        step();
        pulse_start();
        check("t6b_busy", {34'd0, busy_a, rdy_a}, 36'b11);
        send_byte(8'h33); send_byte(8'h44);
        step(); step();
        check("t6b_done", {35'd0, done_a}, 36'd1);
        check("t6b_count", 36'(wq_a.size()), 36'd2);
        check_wr_a("t6b_wr0", 0, 20'h00000, 16'h1122);
        check_wr_a("t6b_wr1", 1, 20'h00001, 16'h3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
